sws_axi_responder: RTL and testbench
====================================

Name: sws_axi_responder

Overview:
AXI4-Lite slave (responder) that exposes the board slide switches to the PS over a 4-register map. It is the target end of the AXI4-Lite master used in the sws IP bench. The block does the following:
- synchronises the raw switch inputs;
- optionally debounces them;
- latches change events into a sticky W1C register.
It sits behind the AXI interconnect at the IP's S00_AXI base address.

Parameters:
C_S00_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
C_S00_AXI_ADDR_WIDTH, 4, AXI address width; addr[3:2] selects the register.
N_SW, 16, number of switch inputs (1..32).
DEB_CNT_W, 20, debounce counter width.

Ports:
s00_axi_aclk  in  1  single clock for the whole block
s00_axi_aresetn  in  1  asynchronous active-low reset
sw_in  in  N_SW  raw switch pins, asynchronous to the clock
sw_irq  out  1  level output, high when (EDGE & CTRL.irq_mask) != 0
s00_axi_awaddr  in  C_S00_AXI_ADDR_WIDTH  write address
s00_axi_awprot  in  3  ignored
s00_axi_awvalid  in  1  write address valid
s00_axi_awready  out  1  write address ready
s00_axi_wdata  in  32  write data
s00_axi_wstrb  in  4  byte enables
s00_axi_wvalid  in  1  write data valid
s00_axi_wready  out  1  write data ready
s00_axi_bresp  out  2  write response; always 2'b00 OKAY
s00_axi_bvalid  out  1  write response valid
s00_axi_bready  in  1  write response ready
s00_axi_araddr  in  C_S00_AXI_ADDR_WIDTH  read address
s00_axi_arprot  in  3  ignored
s00_axi_arvalid  in  1  read address valid
s00_axi_arready  out  1  read address ready
s00_axi_rdata  out  32  read data
s00_axi_rresp  out  2  read response; always 2'b00
s00_axi_rvalid  out  1  read data valid
s00_axi_rready  in  1  read data ready

Behaviour:
Reset values:
- All outputs reset to 0 asynchronously on s00_axi_aresetn low.
- CTRL resets to 0, SCRATCH to 0, EDGE to 0.
- Synchroniser flops reset to 0; the debounced state resets to 0.

Register map (addr[3:2]; addr[1:0] ignored; no unmapped space):
- 0x0 SW_STATE, RO: bits [N_SW-1:0] hold the filtered switch state; upper bits read 0; writes are ignored but still return OKAY.
- 0x4 EDGE, W1C: bit i sets when filtered switch i changes value.
- 0x8 CTRL, RW: [N_SW-1:0] irq_mask; [31:N_SW] reserved, read 0.
- 0xC SCRATCH, RW: full 32 bits, honours wstrb.

Input path:
- Two-flop synchroniser on sw_in.
- The filtered state is the synchroniser output, or the debounced value when SWS_DEBOUNCE_EN is defined.

EDGE register:
- A bit sets when filtered[i] differs from its previous-cycle value.
- Same cycle as a W1C clearing that bit: set wins, so the bit stays 1.

Write channel:
- AW and W are accepted independently, in either order or in the same cycle.
- awready is high while no address is held and bvalid=0; wready is high while no data is held and bvalid=0.
- The register update happens in the cycle after both are held.
- bvalid rises in the same cycle as the update and holds until bready. The holding slots clear when bvalid&bready.
- Maximum one outstanding write.
- Best-case AW+W together: handshake cycle N, update plus bvalid at N+1, next AW accepted at N+2 if bready was high at N+1.
- wstrb applies per byte to CTRL and SCRATCH; for EDGE, a byte lane with strobe 0 clears nothing.

Read channel:
- arready is high when rvalid=0.
- On an ar handshake at cycle N, rdata is registered and rvalid=1 at N+1.
- rdata and rvalid hold stable until rready. Maximum one outstanding read.
- A read of EDGE returns the pre-clear value and does not clear it.

Concurrency and reset:
- Read and write are independent. A read and a write to the same register in the same cycle return the old value.
- Reset mid-transaction drops any held address/data. valid/ready outputs go to 0, and awready/wready/arready rise in the first cycle after reset deasserts.

sw_irq is registered: one cycle after the EDGE/CTRL change.

Optional Feature:
SWS_DEBOUNCE_EN
- Defined:
  - per switch, a DEB_CNT_W counter resets to 0 whenever the synchronised input equals the debounced state;
  - otherwise the counter increments, and when it reaches 2^DEB_CNT_W-1 the debounced state takes the synchronised value and the counter clears;
  - minimum latency from a pin change to SW_STATE is 2 + 2^DEB_CNT_W - 1 cycles.
- Undefined: the filtered state is the synchroniser output, with 2-cycle pin-to-state latency. No counters are instantiated.

Test Plan:
- Write SCRATCH 0x00000001..0x00000004 with wstrb 4'hF, read back after each → last read is 0x00000004 with OKAY; write 0xAABBCCDD with wstrb 4'b0101 over 0x11223344 → readback 0x11BB33DD.
- AW issued 3 cycles before W, then W issued 3 cycles before AW, with bready low for 5 cycles → bvalid held; no second awready until the B handshake; both writes take effect.
- Without SWS_DEBOUNCE_EN: sw_in 0x0000→0x0005 → SW_STATE reads 0x5 and EDGE reads 0x5; write EDGE 0x1 → EDGE reads 0x4.
- CTRL=0x4 with EDGE bit2 set → sw_irq=1; W1C 0x4 in the same cycle as a new toggle on switch 2 → EDGE bit2 stays 1 and sw_irq stays 1.
- With SWS_DEBOUNCE_EN and DEB_CNT_W=4: a 10-cycle glitch on sw_in[0] → no change in SW_STATE or EDGE; a stable change → SW_STATE updates exactly 17 cycles after the pin edge.
- Assert reset while rvalid=1 and AW is held → all valid outputs go to 0 immediately; after release, a read of CTRL returns 0.

Source files
------------

// File: rtl/sws_axi_responder.sv
// AXI4-Lite responder exposing the board slide switches: SW_STATE, sticky W1C EDGE, CTRL irq mask, SCRATCH.
// Define SWS_DEBOUNCE_EN to insert a per-switch saturating-count debouncer after the synchroniser.
module sws_axi_responder #(
    parameter int C_S00_AXI_DATA_WIDTH = 32,
    parameter int C_S00_AXI_ADDR_WIDTH = 4,
    parameter int N_SW                 = 16,
    parameter int DEB_CNT_W            = 20
) (
    input  logic                              s00_axi_aclk,
    input  logic                              s00_axi_aresetn,
    input  logic [N_SW-1:0]                   sw_in,
    output logic                              sw_irq,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                        s00_axi_awprot,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    input  logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S00_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    output logic [1:0]                        s00_axi_bresp,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                        s00_axi_arprot,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready
);

    localparam int DW = C_S00_AXI_DATA_WIDTH;
    localparam int SW = DW / 8;

    localparam logic [1:0] REG_STATE   = 2'd0;
    localparam logic [1:0] REG_EDGE    = 2'd1;
    localparam logic [1:0] REG_CTRL    = 2'd2;
    localparam logic [1:0] REG_SCRATCH = 2'd3;

    function automatic logic [DW-1:0] strb_mask(input logic [SW-1:0] strb);
        logic [DW-1:0] m;
        for (int b = 0; b < SW; b++) begin
            m[b*8 +: 8] = {8{strb[b]}};
        end
        return m;
    endfunction

    function automatic logic [DW-1:0] zext_sw(input logic [N_SW-1:0] v);
        logic [DW-1:0] r;
        r = '0;
        r[N_SW-1:0] = v;
        return r;
    endfunction

    logic [N_SW-1:0] sync1_q, sync2_q;
    logic [N_SW-1:0] filt;
    logic [N_SW-1:0] filt_prev_q;
    logic [N_SW-1:0] edge_flags_q, edge_flags_d;
    logic [N_SW-1:0] ctrl_q, ctrl_d;
    logic [DW-1:0]   scratch_q, scratch_d;
    logic            irq_q, irq_d;

    logic            aw_held_q, aw_held_d;
    logic [1:0]      aw_sel_q, aw_sel_d;
    logic            w_held_q, w_held_d;
    logic [DW-1:0]   w_data_q, w_data_d;
    logic [SW-1:0]   w_strb_q, w_strb_d;
    logic            bvalid_q, bvalid_d;
    logic            awready_q, awready_d;
    logic            wready_q, wready_d;

    logic            arready_q, arready_d;
    logic            rvalid_q, rvalid_d;
    logic [DW-1:0]   rdata_q, rdata_d;

    logic            aw_hs, w_hs, ar_hs, do_write;
    logic [DW-1:0]   bmask, wbits;
    logic [N_SW-1:0] clr;

    // Protection bits and the byte-offset address bits carry no meaning for this map.
    logic unused_inputs;
    assign unused_inputs = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr, s00_axi_araddr};

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sw_in;
            sync2_q <= sync1_q;
        end
    end

`ifdef SWS_DEBOUNCE_EN
    // Counter value at which one more disagreeing cycle commits the new state.
    localparam logic [DEB_CNT_W-1:0] DEB_LAST = {DEB_CNT_W{1'b1}} - 1'b1;

    logic [DEB_CNT_W-1:0] deb_cnt_q [N_SW];
    logic [DEB_CNT_W-1:0] deb_cnt_d [N_SW];
    logic [N_SW-1:0]      deb_state_q, deb_state_d;

    always_comb begin
        deb_state_d = deb_state_q;
        for (int i = 0; i < N_SW; i++) begin
            deb_cnt_d[i] = '0;
            if (sync2_q[i] != deb_state_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) begin
                    deb_state_d[i] = sync2_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            deb_state_q <= '0;
            for (int i = 0; i < N_SW; i++) begin
                deb_cnt_q[i] <= '0;
            end
        end else begin
            deb_state_q <= deb_state_d;
            for (int i = 0; i < N_SW; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
            end
        end
    end

    assign filt = deb_state_q;
`else
    assign filt = sync2_q;
`endif

    // Write channel: AW and W park in their own slots; the write commits on the
    // edge where the second of the pair arrives, so bvalid and the new value appear together.
    always_comb begin
        aw_hs     = s00_axi_awvalid && awready_q;
        w_hs      = s00_axi_wvalid && wready_q;
        aw_held_d = aw_held_q;
        aw_sel_d  = aw_sel_q;
        w_held_d  = w_held_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;

        if (aw_hs) begin
            aw_held_d = 1'b1;
            aw_sel_d  = s00_axi_awaddr[3:2];
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            w_data_d = s00_axi_wdata;
            w_strb_d = s00_axi_wstrb;
        end

        do_write = aw_held_d && w_held_d && !bvalid_q;
        if (do_write) begin
            bvalid_d = 1'b1;
        end else if (bvalid_q && s00_axi_bready) begin
            bvalid_d  = 1'b0;
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
        end

        awready_d = !aw_held_d && !bvalid_d;
        wready_d  = !w_held_d && !bvalid_d;
    end

    always_comb begin
        bmask     = strb_mask(w_strb_d);
        wbits     = w_data_d & bmask;
        ctrl_d    = ctrl_q;
        scratch_d = scratch_q;
        clr       = '0;

        if (do_write) begin
            case (aw_sel_d)
                REG_EDGE:    clr = wbits[N_SW-1:0];
                REG_CTRL:    ctrl_d = (ctrl_q & ~bmask[N_SW-1:0]) | wbits[N_SW-1:0];
                REG_SCRATCH: scratch_d = (scratch_q & ~bmask) | wbits;
                default:     ;
            endcase
        end

        // A fresh change outranks a simultaneous W1C so no event is lost.
        edge_flags_d = (edge_flags_q & ~clr) | (filt ^ filt_prev_q);
        irq_d        = |(edge_flags_q & ctrl_q);
    end

    always_comb begin
        ar_hs    = s00_axi_arvalid && arready_q;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;

        if (ar_hs) begin
            rvalid_d = 1'b1;
            case (s00_axi_araddr[3:2])
                REG_STATE: rdata_d = zext_sw(filt);
                REG_EDGE:  rdata_d = zext_sw(edge_flags_q);
                REG_CTRL:  rdata_d = zext_sw(ctrl_q);
                default:   rdata_d = scratch_q;
            endcase
        end else if (rvalid_q && s00_axi_rready) begin
            rvalid_d = 1'b0;
        end

        arready_d = !rvalid_d;
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            filt_prev_q  <= '0;
            edge_flags_q <= '0;
            ctrl_q       <= '0;
            scratch_q    <= '0;
            irq_q        <= 1'b0;
            aw_held_q    <= 1'b0;
            aw_sel_q     <= '0;
            w_held_q     <= 1'b0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
            bvalid_q     <= 1'b0;
            awready_q    <= 1'b0;
            wready_q     <= 1'b0;
            arready_q    <= 1'b0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
        end else begin
            filt_prev_q  <= filt;
            edge_flags_q <= edge_flags_d;
            ctrl_q       <= ctrl_d;
            scratch_q    <= scratch_d;
            irq_q        <= irq_d;
            aw_held_q    <= aw_held_d;
            aw_sel_q     <= aw_sel_d;
            w_held_q     <= w_held_d;
            w_data_q     <= w_data_d;
            w_strb_q     <= w_strb_d;
            bvalid_q     <= bvalid_d;
            awready_q    <= awready_d;
            wready_q     <= wready_d;
            arready_q    <= arready_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
        end
    end

    assign sw_irq          = irq_q;
    assign s00_axi_awready = awready_q;
    assign s00_axi_wready  = wready_q;
    assign s00_axi_bresp   = 2'b00;
    assign s00_axi_bvalid  = bvalid_q;
    assign s00_axi_arready = arready_q;
    assign s00_axi_rdata   = rdata_q;
    assign s00_axi_rresp   = 2'b00;
    assign s00_axi_rvalid  = rvalid_q;

endmodule

// File: tb/tb_sws_axi_responder.sv
// Scoreboard bench for sws_axi_responder: tasks push expected R/B responses, a negedge monitor pops and compares.
// Builds with or without SWS_DEBOUNCE_EN (DEB_CNT_W = 4 here).
module tb_sws_axi_responder;

    localparam int LAT =
`ifdef SWS_DEBOUNCE_EN
        17;
`else
        2;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] sw_in;
    logic        sw_irq;
    logic [3:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_rdata [$];
    string       exp_rname [$];
    logic [1:0]  exp_bresp [$];

    sws_axi_responder #(
        .C_S00_AXI_DATA_WIDTH(32),
        .C_S00_AXI_ADDR_WIDTH(4),
        .N_SW(16),
        .DEB_CNT_W(4)
    ) dut (
        .s00_axi_aclk(clk),
        .s00_axi_aresetn(rst_n),
        .sw_in(sw_in),
        .sw_irq(sw_irq),
        .s00_axi_awaddr(awaddr),
        .s00_axi_awprot(awprot),
        .s00_axi_awvalid(awvalid),
        .s00_axi_awready(awready),
        .s00_axi_wdata(wdata),
        .s00_axi_wstrb(wstrb),
        .s00_axi_wvalid(wvalid),
        .s00_axi_wready(wready),
        .s00_axi_bresp(bresp),
        .s00_axi_bvalid(bvalid),
        .s00_axi_bready(bready),
        .s00_axi_araddr(araddr),
        .s00_axi_arprot(arprot),
        .s00_axi_arvalid(arvalid),
        .s00_axi_arready(arready),
        .s00_axi_rdata(rdata),
        .s00_axi_rresp(rresp),
        .s00_axi_rvalid(rvalid),
        .s00_axi_rready(rready)
    );

    always #5 clk = ~clk;

    // Monitor: every completed R or B beat is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && rvalid && rready) begin
            checks++;
            if (exp_rdata.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected: got rdata 0x%08h, required no read beat", rdata);
            end else begin
                automatic logic [31:0] e = exp_rdata.pop_front();
                automatic string nm = exp_rname.pop_front();
                if (rdata !== e || rresp !== 2'b00) begin
                    errors++;
                    $display("FAIL %s: got rdata 0x%08h rresp %0d, required 0x%08h rresp 0", nm, rdata, rresp, e);
                end
            end
        end
        if (rst_n && bvalid && bready) begin
            checks++;
            if (exp_bresp.size() == 0) begin
                errors++;
                $display("FAIL wr_unexpected: got bvalid with bresp %0d, required no write beat", bresp);
            end else begin
                automatic logic [1:0] eb = exp_bresp.pop_front();
                if (bresp !== eb) begin
                    errors++;
                    $display("FAIL bresp: got %0d, required %0d", bresp, eb);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL timeout %s: got no handshake within bound, required one", name);
    endtask

    task automatic wait_b();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bvalid && bready) && n < 50);
        if (!(bvalid && bready)) timeout("bresp");
        @(posedge clk); #1;
    endtask

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        logic aw_go, w_go;
        exp_bresp.push_back(2'b00);
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        while ((awvalid || wvalid) && n < 50) begin
            @(negedge clk);
            aw_go = awvalid && awready;
            w_go  = wvalid && wready;
            @(posedge clk); #1;
            if (aw_go) awvalid = 1'b0;
            if (w_go) wvalid = 1'b0;
            n++;
        end
        if (awvalid || wvalid) begin
            timeout("write_accept");
            awvalid = 1'b0; wvalid = 1'b0;
        end else begin
            wait_b();
        end
    endtask

    task automatic axi_read(input logic [3:0] a, input logic [31:0] e, input string name);
        int n;
        logic go;
        exp_rdata.push_back(e);
        exp_rname.push_back(name);
        araddr = a; arvalid = 1'b1;
        n = 0; go = 1'b0;
        while (!go && n < 50) begin
            @(negedge clk);
            go = arready;
            @(posedge clk); #1;
            n++;
        end
        arvalid = 1'b0;
        if (!go) begin
            timeout(name);
        end else begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!rvalid && n < 50);
            if (!rvalid) timeout(name);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int hold, aw_seen, k, irq_hi;
        rst_n = 1'b0; sw_in = '0;
        awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        wdata = '0; wstrb = '0; bready = 1'b1; rready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_awready", awready, 0);
        check("rst_wready", wready, 0);
        check("rst_arready", arready, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_irq", sw_irq, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_awready", awready, 1);
        check("post_rst_arready", arready, 1);

        axi_read(4'h0, 32'h0, "rst_sw_state");
        axi_read(4'h4, 32'h0, "rst_edge");
        axi_read(4'h8, 32'h0, "rst_ctrl");
        axi_read(4'hC, 32'h0, "rst_scratch");

        for (int i = 1; i <= 4; i++) begin
            axi_write(4'hC, i, 4'hF);
            axi_read(4'hC, i, "scratch_seq");
        end
        axi_write(4'hC, 32'h11223344, 4'hF);
        axi_write(4'hD, 32'hAABBCCDD, 4'b0101);
        axi_read(4'hE, 32'h11BB33DD, "scratch_wstrb");

        // AW three cycles ahead of W, B held off for five cycles.
        bready = 1'b0;
        exp_bresp.push_back(2'b00);
        awaddr = 4'h8; awvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0;
        check("no_b_without_w", bvalid, 0);
        repeat (2) @(posedge clk);
        #1;
        wdata = 32'hFFFF00F0; wstrb = 4'hF; wvalid = 1'b1;
        @(posedge clk); #1;
        wvalid = 1'b0;
        hold = 0; aw_seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bvalid) hold++;
            if (awready) aw_seen++;
        end
        check("bvalid_held", hold, 5);
        check("awready_blocked", aw_seen, 0);
        @(posedge clk); #1;
        bready = 1'b1;
        wait_b();
        check("awready_after_b", awready, 1);

        // W three cycles ahead of AW.
        exp_bresp.push_back(2'b00);
        wdata = 32'h5A5A5A5A; wstrb = 4'hF; wvalid = 1'b1;
        @(posedge clk); #1;
        wvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("wready_blocked", wready, 0);
        check("no_b_without_aw", bvalid, 0);
        awaddr = 4'hC; awvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0;
        wait_b();
        axi_read(4'h8, 32'h000000F0, "ctrl_reserved_zero");
        axi_read(4'hC, 32'h5A5A5A5A, "scratch_w_first");

        // Pin-to-state latency, observed through EDGE bit0 and the registered irq.
        axi_write(4'h8, 32'h1, 4'hF);
        sw_in = 16'h0001;
        k = 0;
        while (!sw_irq && k < 60) begin
            @(posedge clk); #1;
            k++;
        end
        check("pin_to_state_latency", k - 2, LAT);
        axi_read(4'h0, 32'h1, "sw_state_bit0");
        axi_read(4'h4, 32'h1, "edge_bit0");
        axi_write(4'h4, 32'h1, 4'hF);
        axi_read(4'h4, 32'h0, "edge_cleared");
        check("irq_dropped", sw_irq, 0);

`ifdef SWS_DEBOUNCE_EN
        sw_in = 16'h0000;
        repeat (10) @(posedge clk);
        #1;
        sw_in = 16'h0001;
        repeat (30) @(posedge clk);
        #1;
        axi_read(4'h0, 32'h1, "glitch_sw_state");
        axi_read(4'h4, 32'h0, "glitch_edge");
        check("glitch_irq", sw_irq, 0);
`else
        sw_in = 16'h0000;
        repeat (5) @(posedge clk);
        #1;
        axi_write(4'h4, 32'hFFFFFFFF, 4'hF);
        axi_read(4'h4, 32'h0, "edge_all_cleared");
        sw_in = 16'h0005;
        repeat (5) @(posedge clk);
        #1;
        axi_read(4'h0, 32'h5, "sw_state_5");
        axi_read(4'h4, 32'h5, "edge_5");
        axi_write(4'h4, 32'h1, 4'hF);
        axi_read(4'h4, 32'h4, "edge_w1c_bit0");
        axi_write(4'h4, 32'h4, 4'h0);
        axi_read(4'h4, 32'h4, "edge_strb0_no_clear");
        axi_write(4'h0, 32'hFFFFFFFF, 4'hF);
        axi_read(4'h0, 32'h5, "sw_state_ro");
        axi_write(4'h8, 32'h4, 4'hF);
        @(posedge clk); #1;
        check("irq_mask_bit2", sw_irq, 1);

        // Toggle switch 2 so its change lands on the same edge as a W1C of bit2.
        sw_in = 16'h0001;
        @(posedge clk); #1;
        @(posedge clk); #1;
        exp_bresp.push_back(2'b00);
        awaddr = 4'h4; wdata = 32'h4; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        irq_hi = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (sw_irq) irq_hi++;
        end
        check("irq_held_set_wins", irq_hi, 6);
        @(posedge clk); #1;
        axi_read(4'h4, 32'h4, "edge_set_wins");
        axi_write(4'h4, 32'h4, 4'hF);
        axi_read(4'h4, 32'h0, "edge_bit2_cleared");
        @(posedge clk); #1;
        check("irq_after_clear", sw_irq, 0);
`endif

        // Reset while a read beat is stalled and an AW is parked.
        rready = 1'b0;
        araddr = 4'hC; arvalid = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0;
        awaddr = 4'h8; awvalid = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0;
        @(posedge clk); #1;
        check("rvalid_stall", rvalid, 1);
        check("rdata_stall", rdata, 32'h5A5A5A5A);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_rvalid", rvalid, 0);
        check("mid_rst_bvalid", bvalid, 0);
        check("mid_rst_awready", awready, 0);
        check("mid_rst_arready", arready, 0);
        check("mid_rst_wready", wready, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        rready = 1'b1;
        @(posedge clk); #1;
        check("rel_awready", awready, 1);
        check("rel_wready", wready, 1);
        check("rel_arready", arready, 1);
        axi_read(4'h8, 32'h0, "ctrl_after_reset");
        axi_read(4'hC, 32'h0, "scratch_after_reset");

        repeat (4) @(posedge clk);
        #1;
        check("rd_queue_drained", exp_rdata.size(), 0);
        check("b_queue_drained", exp_bresp.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
